// File: rtl/store_narrow_unit_pkg.sv
// Shared encodings for the store-path narrower:
// access sizes, fault codes and FSM states.
package store_narrow_unit_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_SIZE     = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/store_narrow_unit_lane_align.sv
// Combinational lane steering: replicates store data onto
// byte lanes, builds byte enables and flags illegal accesses.
module StoreLaneAlign
    import store_narrow_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misalign,
    output logic        bad_size
);

    // Little-endian lane mapping and alignment check per size
    always_comb begin
        wdata    = '0;
        be       = '0;
        misalign = 1'b0;
        bad_size = 1'b0;
        unique case (size)
            SZ_B: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr;
            end
            SZ_H: begin
                wdata    = {2{data[15:0]}};
                be       = addr[1] ? 4'b1100 : 4'b0011;
                misalign = addr[0];
            end
            SZ_W: begin
                wdata    = data;
                be       = 4'b1111;
                misalign = |addr;
            end
            default: begin
                bad_size = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Store-path narrower: accepts a store, runs a req/ack write
// to data memory with a timeout, reports Done or Fault.
module store_narrow_unit
    import store_narrow_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        St_Valid,
    output logic        St_Ready,
    input  logic [1:0]  St_Size,
    input  logic [31:0] St_Addr,
    input  logic [31:0] St_Data,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    output logic [3:0]  Mem_BE,
    input  logic        Mem_Ack,
    output logic        Done,
    output logic        Fault,
    output logic [1:0]  Fault_Code
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [31:0]   lane_wdata;
    logic [3:0]    lane_be;
    logic          misalign;
    logic          bad_size;

    StoreLaneAlign u_align (
        .size     (St_Size),
        .addr     (St_Addr[1:0]),
        .data     (St_Data),
        .wdata    (lane_wdata),
        .be       (lane_be),
        .misalign (misalign),
        .bad_size (bad_size)
    );

    assign St_Ready = (state == IDLE);

    // FSM, timeout counter and registered memory/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            Mem_Req    <= 1'b0;
            Mem_Addr   <= '0;
            Mem_WData  <= '0;
            Mem_BE     <= '0;
            Done       <= 1'b0;
            Fault      <= 1'b0;
            Fault_Code <= FLT_NONE;
        end else begin
            Done       <= 1'b0;
            Fault      <= 1'b0;
            Fault_Code <= FLT_NONE;
            unique case (state)
                IDLE: begin
                    if (St_Valid) begin
                        if (bad_size) begin
                            Fault      <= 1'b1;
                            Fault_Code <= FLT_SIZE;
                        end else if (misalign) begin
                            Fault      <= 1'b1;
                            Fault_Code <= FLT_MISALIGN;
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            Mem_Req   <= 1'b1;
                            Mem_Addr  <= {St_Addr[31:2], 2'b00};
                            Mem_WData <= lane_wdata;
                            Mem_BE    <= lane_be;
                        end
                    end
                end
                REQ: begin
                    // An ack in the final allowed cycle still wins
                    if (Mem_Ack) begin
                        state   <= IDLE;
                        Mem_Req <= 1'b0;
                        Done    <= 1'b1;
                    end else if (cnt == LAST) begin
                        state      <= IDLE;
                        Mem_Req    <= 1'b0;
                        Fault      <= 1'b1;
                        Fault_Code <= FLT_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit with TIMEOUT=4:
// lane steering, faults, timeout, reset abort, back-to-back.
module tb_store_narrow_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        St_Valid;
    logic        St_Ready;
    logic [1:0]  St_Size;
    logic [31:0] St_Addr;
    logic [31:0] St_Data;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [3:0]  Mem_BE;
    logic        Mem_Ack;
    logic        Done;
    logic        Fault;
    logic [1:0]  Fault_Code;

    int n_cmp = 0;
    int n_err = 0;

    store_narrow_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .St_Valid   (St_Valid),
        .St_Ready   (St_Ready),
        .St_Size    (St_Size),
        .St_Addr    (St_Addr),
        .St_Data    (St_Data),
        .Mem_Req    (Mem_Req),
        .Mem_Addr   (Mem_Addr),
        .Mem_WData  (Mem_WData),
        .Mem_BE     (Mem_BE),
        .Mem_Ack    (Mem_Ack),
        .Done       (Done),
        .Fault      (Fault),
        .Fault_Code (Fault_Code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Quiet-state checks used after completions
    task automatic check_idle(input string tag, input logic d,
                              input logic f, input logic [1:0] c);
        check({tag, ".ready"}, 32'(St_Ready), 32'd1);
        check({tag, ".req"}, 32'(Mem_Req), 32'd0);
        check({tag, ".done"}, 32'(Done), 32'(d));
        check({tag, ".fault"}, 32'(Fault), 32'(f));
        check({tag, ".code"}, 32'(Fault_Code), 32'(c));
    endtask

    // Legal store; ack_at = cycle of ack, 0 = never. Returns in
    // the Done/Fault cycle without stepping further.
    task automatic store(input string tag, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d,
                         input int ack_at, input logic [31:0] ew,
                         input logic [3:0] ebe);
        St_Valid = 1'b1;
        St_Size  = sz;
        St_Addr  = a;
        St_Data  = d;
        step();
        St_Valid = 1'b0;
        St_Data  = ~d;
        St_Addr  = ~a;
        for (int c = 1; c <= TO; c++) begin
            check({tag, ".req"}, 32'(Mem_Req), 32'd1);
            check({tag, ".ready"}, 32'(St_Ready), 32'd0);
            check({tag, ".addr"}, Mem_Addr, {a[31:2], 2'b00});
            check({tag, ".wdata"}, Mem_WData, ew);
            check({tag, ".be"}, 32'(Mem_BE), 32'(ebe));
            check({tag, ".nodone"}, 32'(Done), 32'd0);
            Mem_Ack = (c == ack_at);
            step();
            Mem_Ack = 1'b0;
            if (c == ack_at) break;
        end
        if (ack_at >= 1 && ack_at <= TO)
            check_idle({tag, ".end"}, 1'b1, 1'b0, 2'b00);
        else
            check_idle({tag, ".end"}, 1'b0, 1'b1, 2'b11);
    endtask

    // Illegal store: fault next cycle, never a memory request
    task automatic bad(input string tag, input logic [1:0] sz,
                       input logic [31:0] a, input logic [1:0] code);
        St_Valid = 1'b1;
        St_Size  = sz;
        St_Addr  = a;
        St_Data  = 32'h1234_5678;
        step();
        St_Valid = 1'b0;
        check_idle({tag, ".c1"}, 1'b0, 1'b1, code);
        step();
        check_idle({tag, ".c2"}, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        reset    = 1'b1;
        St_Valid = 1'b0;
        St_Size  = 2'b00;
        St_Addr  = '0;
        St_Data  = '0;
        Mem_Ack  = 1'b0;
        step();
        step();
        check_idle("rst", 1'b0, 1'b0, 2'b00);
        check("rst.addr", Mem_Addr, 32'h0);
        check("rst.wdata", Mem_WData, 32'h0);
        check("rst.be", 32'(Mem_BE), 32'h0);
        reset = 1'b0;
        step();

        store("sb3", 2'b00, 32'h0000_1003, 32'hAABB_CCDD, 1,
              32'hDDDD_DDDD, 4'b1000);
        step();
        check_idle("sb3.after", 1'b0, 1'b0, 2'b00);

        store("sh2", 2'b01, 32'h0000_2002, 32'h1234_5678, 3,
              32'h5678_5678, 4'b1100);
        step();
        check_idle("sh2.after", 1'b0, 1'b0, 2'b00);

        store("sb1", 2'b00, 32'h0000_7001, 32'h0000_00A5, 2,
              32'hA5A5_A5A5, 4'b0010);
        step();

        bad("sh_mis", 2'b01, 32'h0000_2001, 2'b01);
        bad("sw_mis", 2'b10, 32'h0000_3002, 2'b01);
        bad("sz_bad", 2'b11, 32'h0000_3003, 2'b10);

        store("tmo", 2'b10, 32'h0000_8000, 32'h0BAD_F00D, 0,
              32'h0BAD_F00D, 4'b1111);
        step();
        check_idle("tmo.after", 1'b0, 1'b0, 2'b00);

        store("ack4", 2'b10, 32'h0000_8004, 32'h600D_600D, 4,
              32'h600D_600D, 4'b1111);
        step();

        St_Valid = 1'b1;
        St_Size  = 2'b10;
        St_Addr  = 32'h0000_5000;
        St_Data  = 32'h5555_AAAA;
        step();
        St_Valid = 1'b0;
        step();
        check("abort.req", 32'(Mem_Req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("abort.c3", 1'b0, 1'b0, 2'b00);
        Mem_Ack = 1'b1;
        step();
        Mem_Ack = 1'b0;
        check_idle("abort.c4", 1'b0, 1'b0, 2'b00);
        step();
        check_idle("abort.c5", 1'b0, 1'b0, 2'b00);

        store("shlo", 2'b01, 32'h0000_6000, 32'hFFFF_BEEF, 1,
              32'hBEEF_BEEF, 4'b0011);
        store("b2b", 2'b10, 32'h0000_4000, 32'hCAFE_F00D, 2,
              32'hCAFE_F00D, 4'b1111);
        step();
        check_idle("b2b.after", 1'b0, 1'b0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-path data narrower for the single-cycle/multicycle MIPS datapath, the write-side counterpart of the load-path sign/zero extension. It accepts a 32-bit register value plus a byte address and access size (SB/SH/SW), then narrows and replicates the data onto the correct byte lanes. It generates byte enables, runs a request/acknowledge transaction to data memory with a timeout, and reports completion or a fault back to the control unit.

## Interface
- `TIMEOUT`, default 16: maximum consecutive `Mem_Req` cycles without `Mem_Ack` before a timeout fault; legal range ≥1.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `St_Valid` in 1: store request from the pipeline.
- `St_Ready` out 1: unit idle; a request is accepted on an edge where `St_Valid && St_Ready`.
- `St_Size` in 2: 00 byte (SB), 01 halfword (SH), 10 word (SW), 11 reserved.
- `St_Addr` in 32: byte address (ALU result).
- `St_Data` in 32: rt register value.
- `Mem_Req` out 1: memory write request.
- `Mem_Addr` out 32: word-aligned address `{St_Addr[31:2],2'b00}`.
- `Mem_WData` out 32: lane-replicated write data.
- `Mem_BE` out 4: byte enables; bit n selects byte n (`[8n+7:8n]`).
- `Mem_Ack` in 1: memory has accepted the write.
- `Done` out 1: one-cycle pulse on successful completion.
- `Fault` out 1: one-cycle pulse on a failed store.
- `Fault_Code` out 2: 01 misaligned, 10 bad size, 11 timeout; valid only while `Fault`=1, otherwise 00.

## Operation
- Little-endian lane mapping:
  - Byte: `Mem_WData={4{St_Data[7:0]}}`, `Mem_BE=4'b0001<<St_Addr[1:0]`.
  - Half: `Mem_WData={2{St_Data[15:0]}}`, `Mem_BE = St_Addr[1] ? 1100 : 0011`.
  - Word: `Mem_WData=St_Data`, `Mem_BE=1111`.
- Alignment rules: half needs `St_Addr[0]=0`; word needs `St_Addr[1:0]=00`; byte is always aligned.
- Fault priority: bad size (11) over misaligned.
- FSM states:
  - IDLE: `St_Ready`=1. On accept, go to REQ if legal; if illegal, stay in IDLE and pulse `Fault` next cycle with no memory request.
  - REQ: `Mem_Req`=1 with `Mem_Addr`/`Mem_WData`/`Mem_BE` held stable. If `Mem_Ack`=1, go to IDLE and pulse `Done`. If the timeout count is reached, go to IDLE and pulse `Fault` with code 11.
- Timeout counter:
  - Width `$clog2(TIMEOUT+1)`, cleared on entry to REQ, incremented each REQ cycle without ack.
  - An ack arriving in the TIMEOUT-th cycle wins: `Done`, not `Fault`.
- Ignored inputs: `Mem_Ack` in IDLE; `St_Valid` while `St_Ready`=0 (pipeline must hold the request).
- Reset values: `St_Ready`=1, `Mem_Req`=0, `Mem_Addr`=0, `Mem_WData`=0, `Mem_BE`=0, `Done`=0, `Fault`=0, `Fault_Code`=00, counter 0, state IDLE.
- Reset asserted mid-REQ: `Mem_Req` drops at that edge; no `Done`/`Fault` is issued for the aborted store.

## Timing
- Accept at edge 0 → `Mem_Req`=1 in cycle 1.
- Ack sampled in cycle k → `Done`=1 and `St_Ready`=1 in cycle k+1.
- Best-case latency is 2 cycles (ack in cycle 1, `Done` in cycle 2).
- Back-to-back: a new request may be accepted in the same cycle `Done` is high.
- Illegal request accepted at edge 0 → `Fault` in cycle 1 with `St_Ready` still 1.
- Timeout: no ack in cycles 1..TIMEOUT → `Mem_Req`=0 and `Fault`=1 (code 11) in cycle TIMEOUT+1.
- All outputs are registered; `St_Ready` decodes directly from the state register.

## Structure
- Shared package/header holds:
  - size encodings: `SZ_B`, `SZ_H`, `SZ_W`;
  - fault codes: `FLT_NONE`, `FLT_MISALIGN`, `FLT_SIZE`, `FLT_TIMEOUT`;
  - FSM state encodings: IDLE, REQ.
- One combinational sub-module, `StoreLaneAlign`:
  - inputs: size, addr[1:0], data;
  - outputs: wdata, be, misalign, bad_size.
- The top level contains the FSM, the timeout counter, and the output registers.

## Test plan
- SB, addr 0x1003, data 0xAABBCCDD, ack in cycle 1:
  - `Mem_Addr`=0x1000, `Mem_WData`=0xDDDDDDDD, `Mem_BE`=1000;
  - `Done` in cycle 2.
- SH, addr 0x2002, data 0x12345678, ack in cycle 3:
  - `Mem_WData`=0x56785678, `Mem_BE`=1100;
  - outputs held stable in cycles 1–3; `Done` in cycle 4.
- SH at 0x2001 → `Fault`=1, code 01, in cycle 1; `Mem_Req` never asserted.
- SW at 0x3002 → `Fault`=1, code 01.
- Size 11 at 0x3003 → `Fault`=1, code 10 (bad size outranks misaligned).
- TIMEOUT=4, no ack → `Mem_Req` high in cycles 1–4, `Fault` code 11 in cycle 5.
  - Repeat with ack in cycle 4 → `Done`, no `Fault`.
- Reset asserted in cycle 2 of REQ → `Mem_Req`=0 from the next cycle, no `Done`/`Fault`.
  - Then issue SW 0x4000 back-to-back with the prior `Done` → accepted in the `Done` cycle.
